true_dual_port_ram: RTL and testbench

TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

---
 rtl/true_dual_port_ram_pkg.sv | 25 ++
 rtl/true_dual_port_ram_rd_pipe.sv | 62 ++++++
 rtl/true_dual_port_ram.sv | 219 +++++++++++++++++++++
 tb/tb_true_dual_port_ram.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/true_dual_port_ram_pkg.sv
// Shared definitions for the true dual-port RAM.
// Holds the same-port read-during-write mode constants, the controller
// state encoding and a helper that sizes the address bus from the depth.
package true_dual_port_ram_pkg;

  // Same-port read-during-write behaviour selected by WRITE_MODE.
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  // INIT walks the array writing zeros; READY serves port requests.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  // Address width for a given depth; a one-word array still gets one bit.
  function automatic int addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/true_dual_port_ram_rd_pipe.sv
// ram_rd_pipe: per-port read-data / data-valid latency stages.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   req_vld          request accepted at this edge
//   req_data         word to return for that request
//   dout, dvalid     returned word and its one-cycle qualifier,
//                    RD_LATENCY cycles after the sampling edge
module ram_rd_pipe
  import true_dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);

  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_vld_r;

  // First stage: capture the word chosen at the sampling edge; hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_r <= '0;
      s1_vld_r  <= 1'b0;
    end else begin
      s1_vld_r <= req_vld;
      if (req_vld) begin
        s1_data_r <= req_data;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_vld_r;

      // Second stage: plain retiming register, so back-to-back requests stay in order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data_r <= '0;
          s2_vld_r  <= 1'b0;
        end else begin
          s2_data_r <= s1_data_r;
          s2_vld_r  <= s1_vld_r;
        end
      end

      assign dout   = s2_data_r;
      assign dvalid = s2_vld_r;
    end else begin : g_lat1
      assign dout   = s1_data_r;
      assign dvalid = s1_vld_r;
    end
  endgenerate

endmodule

// File: rtl/true_dual_port_ram.sv
// true_dual_port_ram: two symmetric read/write ports on one clock, with
// byte enables, optional zero-fill after reset and a same-address flag.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en_x, we_x, be_x            request strobe, write select, byte enables
//   addr_x, din_x               word address and write data
//   dout_x, dvalid_x            returned word and its one-cycle qualifier
//   init_busy                   high while the array is being zero-filled
//   collision                   one-cycle pulse after a same-address access
//                               in which at least one port wrote
module true_dual_port_ram
  import true_dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = addr_width(DEPTH),
  localparam int NB            = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [NB-1:0]         be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  dvalid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [NB-1:0]         be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dvalid_b,
  output logic                  init_busy,
  output logic                  collision
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  ram_state_e            state_r;
  ram_state_e            state_nxt_s;
  logic [ADDR_W-1:0]     fill_cnt_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic                  init_busy_s;
  logic                  acc_a_s, acc_b_s;
  logic                  inr_a_s, inr_b_s;
  logic                  wr_a_s, wr_b_s;
  logic                  same_addr_s;
  logic                  coll_s;
  logic                  collision_r;
  logic [DATA_WIDTH-1:0] old_a_s, old_b_s;
  logic [DATA_WIDTH-1:0] word_a_s, word_b_s;
  logic [DATA_WIDTH-1:0] rdata_a_s, rdata_b_s;

  // Replace the bytes of base selected by be with the matching bytes of wdata.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = base;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = base[8*i +: 8];
      end
    end
    return res;
  endfunction

  // State register and zero-fill address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      fill_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_INIT) begin
        fill_cnt_r <= (fill_cnt_r == LAST_C) ? '0 : fill_cnt_r + ADDR_W'(1);
      end
    end
  end

  // Next state: leave INIT once the last word has been cleared.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (fill_cnt_r == LAST_C) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // State decode: port requests are ignored while the fill runs.
  always_comb begin
    init_busy_s = 1'b0;
    case (state_r)
      ST_INIT:  init_busy_s = 1'b1;
      ST_READY: init_busy_s = 1'b0;
      default:  init_busy_s = 1'b1;
    endcase
  end

  // Request decode, byte merging and the word each port returns.
  always_comb begin
    acc_a_s     = en_a && !init_busy_s;
    acc_b_s     = en_b && !init_busy_s;
    inr_a_s     = ({1'b0, addr_a} < DEPTH_C);
    inr_b_s     = ({1'b0, addr_b} < DEPTH_C);
    wr_a_s      = acc_a_s && we_a && inr_a_s;
    wr_b_s      = acc_b_s && we_b && inr_b_s;
    same_addr_s = (addr_a == addr_b);

    if (inr_a_s) begin
      old_a_s = mem_r[addr_a];
    end else begin
      old_a_s = '0;
    end
    if (inr_b_s) begin
      old_b_s = mem_r[addr_b];
    end else begin
      old_b_s = '0;
    end

    // On a shared address A is merged over B's result, so A wins per byte
    // and B survives only where be_a is clear.
    word_b_s = merge_bytes(old_b_s, din_b, be_b);
    if (wr_b_s && same_addr_s) begin
      word_a_s = merge_bytes(word_b_s, din_a, be_a);
    end else begin
      word_a_s = merge_bytes(old_a_s, din_a, be_a);
    end

    // Cross-port reads always see the pre-write word; only a port's own
    // write can return the post-write word, and only in write-first mode.
    if (!inr_a_s) begin
      rdata_a_s = '0;
    end else if (we_a && (WRITE_MODE == WM_WRITE_FIRST)) begin
      rdata_a_s = word_a_s;
    end else begin
      rdata_a_s = old_a_s;
    end

    if (!inr_b_s) begin
      rdata_b_s = '0;
    end else if (we_b && (WRITE_MODE == WM_WRITE_FIRST)) begin
      rdata_b_s = (wr_a_s && same_addr_s) ? word_a_s : word_b_s;
    end else begin
      rdata_b_s = old_b_s;
    end

    coll_s = acc_a_s && acc_b_s && inr_a_s && inr_b_s && same_addr_s && (we_a || we_b);
  end

  // Array update: zero-fill while initialising, else port writes (A's word already contains B's bytes on overlap).
  always_ff @(posedge clk) begin
    if (init_busy_s) begin
      mem_r[fill_cnt_r] <= '0;
    end else begin
      if (wr_b_s && !(wr_a_s && same_addr_s)) begin
        mem_r[addr_b] <= word_b_s;
      end
      if (wr_a_s) begin
        mem_r[addr_a] <= word_a_s;
      end
    end
  end

  // Collision flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_r <= 1'b0;
    end else begin
      collision_r <= coll_s;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (acc_a_s),
    .req_data (rdata_a_s),
    .dout     (dout_a),
    .dvalid   (dvalid_a)
  );

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (acc_b_s),
    .req_data (rdata_b_s),
    .dout     (dout_b),
    .dvalid   (dvalid_b)
  );

  assign init_busy = init_busy_s;
  assign collision = collision_r;

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Self-checking bench: two RAM configurations driven by identical stimulus
// (256 words / latency 1 / read-first, and 200 words / latency 2 /
// write-first). A word-level reference model per configuration pushes the
// expected response of every accepted request into a per-port queue; a
// monitor pops and compares whenever dvalid is seen.
module tb_true_dual_port_ram;

  localparam int M_DEPTH [2] = '{256, 200};
  localparam int M_LAT   [2] = '{1, 2};
  localparam int M_WM    [2] = '{0, 1};

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a_s = 1'b0, we_a_s = 1'b0, en_b_s = 1'b0, we_b_s = 1'b0;
  logic [3:0]  be_a_s = 4'h0, be_b_s = 4'h0;
  logic [7:0]  addr_a_s = 8'h00, addr_b_s = 8'h00;
  logic [31:0] din_a_s = 32'h0, din_b_s = 32'h0;

  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        dvalid_a0, dvalid_b0, dvalid_a1, dvalid_b1;
  logic        busy0, busy1, coll0, coll1;

  logic [31:0] dout_s   [4];
  logic        dvalid_s [4];
  logic        busy_s   [2];
  logic        coll_s   [2];

  logic [31:0] mmem [2][256];
  int          busy_left [2] = '{256, 200};
  logic        exp_coll  [2] = '{1'b0, 1'b0};
  exp_t        sb [4][$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  true_dual_port_ram #(
    .DATA_WIDTH(32), .DEPTH(256), .RD_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a_s), .we_a(we_a_s), .be_a(be_a_s), .addr_a(addr_a_s), .din_a(din_a_s),
    .dout_a(dout_a0), .dvalid_a(dvalid_a0),
    .en_b(en_b_s), .we_b(we_b_s), .be_b(be_b_s), .addr_b(addr_b_s), .din_b(din_b_s),
    .dout_b(dout_b0), .dvalid_b(dvalid_b0),
    .init_busy(busy0), .collision(coll0)
  );

  true_dual_port_ram #(
    .DATA_WIDTH(32), .DEPTH(200), .RD_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a_s), .we_a(we_a_s), .be_a(be_a_s), .addr_a(addr_a_s), .din_a(din_a_s),
    .dout_a(dout_a1), .dvalid_a(dvalid_a1),
    .en_b(en_b_s), .we_b(we_b_s), .be_b(be_b_s), .addr_b(addr_b_s), .din_b(din_b_s),
    .dout_b(dout_b1), .dvalid_b(dvalid_b1),
    .init_busy(busy1), .collision(coll1)
  );

  assign dout_s[0] = dout_a0;   assign dvalid_s[0] = dvalid_a0;
  assign dout_s[1] = dout_b0;   assign dvalid_s[1] = dvalid_b0;
  assign dout_s[2] = dout_a1;   assign dvalid_s[2] = dvalid_a1;
  assign dout_s[3] = dout_b1;   assign dvalid_s[3] = dvalid_b1;
  assign busy_s[0] = busy0;     assign busy_s[1] = busy1;
  assign coll_s[0] = coll0;     assign coll_s[1] = coll1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted cycle for configuration m.
  task automatic model_access(input int m);
    bit          ina, inb, wa, wb;
    logic [31:0] old_a, old_b, ra, rb;
    ina   = (int'(addr_a_s) < M_DEPTH[m]);
    inb   = (int'(addr_b_s) < M_DEPTH[m]);
    wa    = en_a_s && we_a_s && ina;
    wb    = en_b_s && we_b_s && inb;
    old_a = ina ? mmem[m][addr_a_s] : 32'h0;
    old_b = inb ? mmem[m][addr_b_s] : 32'h0;
    if (wb) begin
      for (int i = 0; i < 4; i++) begin
        if (be_b_s[i] && !(wa && addr_a_s == addr_b_s && be_a_s[i])) begin
          mmem[m][addr_b_s][8*i +: 8] = din_b_s[8*i +: 8];
        end
      end
    end
    if (wa) begin
      for (int i = 0; i < 4; i++) begin
        if (be_a_s[i]) begin
          mmem[m][addr_a_s][8*i +: 8] = din_a_s[8*i +: 8];
        end
      end
    end
    ra = !ina ? 32'h0 : (we_a_s && M_WM[m] == 1) ? mmem[m][addr_a_s] : old_a;
    rb = !inb ? 32'h0 : (we_b_s && M_WM[m] == 1) ? mmem[m][addr_b_s] : old_b;
    if (en_a_s) sb[2*m].push_back('{ra, cyc + M_LAT[m] - 1});
    if (en_b_s) sb[2*m+1].push_back('{rb, cyc + M_LAT[m] - 1});
    exp_coll[m] = en_a_s && en_b_s && ina && inb && (addr_a_s == addr_b_s) && (we_a_s || we_b_s);
  endtask

  // Model: advances at every rising edge using the inputs sampled there.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        busy_left[m] = M_DEPTH[m];
        sb[2*m].delete();
        sb[2*m+1].delete();
        exp_coll[m] = 1'b0;
      end else if (busy_left[m] > 0) begin
        busy_left[m] = busy_left[m] - 1;
        exp_coll[m] = 1'b0;
        if (busy_left[m] == 0) begin
          for (int i = 0; i < 256; i++) mmem[m][i] = 32'h0;
        end
      end else begin
        model_access(m);
      end
    end
  end

  // Monitor: compares DUT outputs just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (dvalid_s[k]) begin
        check(sb[k].size() > 0, $sformatf("spurious_dvalid[%0d]", k), 32'd1, 32'd0);
        if (sb[k].size() > 0) begin
          e = sb[k].pop_front();
          check(dout_s[k] === e.data, $sformatf("dout[%0d]", k), dout_s[k], e.data);
          check(e.due == cyc, $sformatf("latency[%0d]", k), 32'(cyc), 32'(e.due));
        end
      end else begin
        check(!(sb[k].size() > 0 && sb[k][0].due <= cyc), $sformatf("missing_dvalid[%0d]", k), 32'd0, 32'd1);
        if (sb[k].size() > 0 && sb[k][0].due <= cyc) void'(sb[k].pop_front());
      end
    end
    for (int m = 0; m < 2; m++) begin
      check(busy_s[m] === (busy_left[m] > 0), $sformatf("init_busy[%0d]", m), 32'(busy_s[m]), 32'(busy_left[m] > 0));
      check(coll_s[m] === exp_coll[m], $sformatf("collision[%0d]", m), 32'(coll_s[m]), 32'(exp_coll[m]));
    end
  end

  task automatic drive(input bit ea, input bit wa, input logic [3:0] bea, input logic [7:0] aa, input logic [31:0] da,
                       input bit eb, input bit wb, input logic [3:0] beb, input logic [7:0] ab, input logic [31:0] db);
    @(negedge clk);
    en_a_s = ea; we_a_s = wa; be_a_s = bea; addr_a_s = aa; din_a_s = da;
    en_b_s = eb; we_b_s = wb; be_b_s = beb; addr_b_s = ab; din_b_s = db;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 9) < 7) return 8'($urandom_range(0, 15));
    else return 8'($urandom_range(190, 255));
  endfunction

  task automatic random_ops(input int n);
    logic [7:0] aa, ab;
    for (int i = 0; i < n; i++) begin
      aa = pick_addr();
      ab = ($urandom_range(0, 3) == 0) ? aa : pick_addr();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 4'($urandom), aa, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 4'($urandom), ab, $urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_a_s = 1'b0; en_b_s = 1'b0; we_a_s = 1'b0; we_b_s = 1'b0;
    repeat (2) @(negedge clk);
    check(dout_a0 === 32'h0, "reset_dout_a0", dout_a0, 32'h0);
    check(dout_b0 === 32'h0, "reset_dout_b0", dout_b0, 32'h0);
    check(dout_a1 === 32'h0, "reset_dout_a1", dout_a1, 32'h0);
    check(dout_b1 === 32'h0, "reset_dout_b1", dout_b1, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Requests during the fill are ignored; reset again part-way through.
    random_ops(100);
    do_reset();
    random_ops(150);
    idle(110);
    // Filled word reads back as zero (out of range for the 200-word array).
    drive(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
    // Byte-enabled write over an existing word, then read back.
    drive(1'b1, 1'b1, 4'hF, 8'd5, 32'h11223344, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive(1'b1, 1'b1, 4'b0101, 8'd5, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 8'd5, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    // Both ports write the same word; A wins per byte.
    drive(1'b1, 1'b1, 4'b0001, 8'd9, 32'h000000AA, 1'b1, 1'b1, 4'b0011, 8'd9, 32'h0000BB00);
    drive(1'b1, 1'b0, 4'h0, 8'd9, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    // Read on A while B writes the same word.
    drive(1'b1, 1'b1, 4'hF, 8'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 4'h0, 8'd3, 32'h0, 1'b1, 1'b1, 4'hF, 8'd3, 32'h00000055);
    drive(1'b1, 1'b0, 4'h0, 8'd3, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    // Zero byte-enable write: no change, still a response.
    drive(1'b1, 1'b1, 4'h0, 8'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    // Back-to-back reads on port B.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 1'b0, 4'h0, 8'(i), 32'h0);
    idle(4);
    random_ops(1500);
    // Reset while reads are in flight, then refill and run again.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'h0, 8'(i), 32'h0, 1'b1, 1'b0, 4'h0, 8'(i + 4), 32'h0);
    do_reset();
    idle(260);
    random_ops(300);
    idle(6);
    for (int k = 0; k < 4; k++) begin
      check(sb[k].size() == 0, $sformatf("drain[%0d]", k), 32'(sb[k].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
